// File: rtl/sysid_check_master_pkg.sv
// rtl/sysid_check_master_pkg.sv - shared types and constants for the system-ID check master
package sysid_check_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ID_REQ,
    ST_ID_WAIT,
    ST_TS_REQ,
    ST_TS_WAIT,
    ST_DONE
  } sysid_chk_state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // Also consumed by the HPS header generator; keep in sync with the bitstream build
  localparam logic [31:0] SYSID_DEFAULT_EXPECTED_ID        = 32'h0000_0000;
  localparam logic [31:0] SYSID_DEFAULT_EXPECTED_TIMESTAMP = 32'd1463101460;

  localparam int SYSID_CNT_W = 16;

endpackage

// File: rtl/avm_single_read.sv
// rtl/avm_single_read.sv - single-outstanding Avalon-MM read engine with per-transaction timeout
module avm_single_read
  import sysid_check_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        launch_i,
  input  logic        req_i,
  input  logic        wait_i,
  input  logic        addr_i,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        accept_o,
  output logic        capture_o,
  output logic        expire_o,
  output logic [31:0] data_o
);

  localparam logic [SYSID_CNT_W-1:0] LIMIT = SYSID_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [SYSID_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    avm_read    = req_i;
    avm_address = req_i ? addr_i : 1'b0;
    accept_o    = req_i & ~avm_waitrequest;
    // A zero-latency slave can return data in the accept cycle itself
    capture_o   = (accept_o | wait_i) & avm_readdatavalid;
    expire_o    = (req_i | wait_i) & (cnt_q == LIMIT) & ~capture_o;
    data_o      = avm_readdata;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (launch_i) begin
      cnt_d = '0;
    end else if (req_i | wait_i) begin
      cnt_d = cnt_q + SYSID_CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sysid_check_master.sv
// rtl/sysid_check_master.sv - reads system ID and build timestamp, compares against expected values
module sysid_check_master
  import sysid_check_master_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_EXPECTED_TIMESTAMP,
  parameter int          TIMEOUT_CYCLES     = 256
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  sysid_chk_state_t state_q, state_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;

  logic        launch, req_active, wait_active, addr_sel;
  logic        accept, capture, expire;
  logic [31:0] rd_data;

  avm_single_read #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rd (
    .clock            (clock),
    .reset_n          (reset_n),
    .launch_i         (launch),
    .req_i            (req_active),
    .wait_i           (wait_active),
    .addr_i           (addr_sel),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .accept_o         (accept),
    .capture_o        (capture),
    .expire_o         (expire),
    .data_o           (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    id_ok_d     = id_ok_q;
    ts_ok_d     = ts_ok_q;
    timeout_d   = timeout_q;
    id_value_d  = id_value_q;
    ts_value_d  = ts_value_q;
    launch      = 1'b0;
    req_active  = (state_q == ST_ID_REQ) || (state_q == ST_TS_REQ);
    wait_active = (state_q == ST_ID_WAIT) || (state_q == ST_TS_WAIT);
    addr_sel    = (state_q == ST_TS_REQ) ? SYSID_ADDR_TS : SYSID_ADDR_ID;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_ID_REQ;
          launch     = 1'b1;
          id_ok_d    = 1'b0;
          ts_ok_d    = 1'b0;
          timeout_d  = 1'b0;
          id_value_d = '0;
          ts_value_d = '0;
        end
      end
      ST_ID_REQ, ST_ID_WAIT: begin
        if (capture) begin
          id_value_d = rd_data;
          id_ok_d    = (rd_data == EXPECTED_ID);
          state_d    = ST_TS_REQ;
          launch     = 1'b1;
        end else if (expire) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else if ((state_q == ST_ID_REQ) && accept) begin
          state_d = ST_ID_WAIT;
        end
      end
      ST_TS_REQ, ST_TS_WAIT: begin
        if (capture) begin
          ts_value_d = rd_data;
          ts_ok_d    = (rd_data == EXPECTED_TIMESTAMP);
          state_d    = ST_DONE;
        end else if (expire) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else if ((state_q == ST_TS_REQ) && accept) begin
          state_d = ST_TS_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
    end else begin
      state_q    <= state_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  assign busy     = req_active | wait_active;
  assign done     = (state_q == ST_DONE);
  assign id_ok    = id_ok_q;
  assign ts_ok    = ts_ok_q;
  assign timeout  = timeout_q;
  assign pass     = id_ok_q & ts_ok_q & done & ~timeout_q;
  assign id_value = id_value_q;
  assign ts_value = ts_value_q;

endmodule

// File: doc/sysid_check_master.md
Name: sysid_check_master

Overview:
- Avalon-MM read master that interrogates the system-ID slave at boot or on request.
- Reads word 0 (system ID) and word 1 (build timestamp), then compares both against expected parameters.
- Reports pass/fail and timeout status to the HPS-side control/status logic or the accelerator bring-up sequencer.
- Blocks accelerator enable until the bitstream identity is confirmed.

Parameters:
- EXPECTED_ID, 32'h0000_0000, value required at word address 0
- EXPECTED_TIMESTAMP, 32'd1463101460, value required at word address 1
- TIMEOUT_CYCLES, 256, max cycles per transaction (request plus wait for data) before abort; range 2..65535

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a check sequence
- avm_address  out  1  word address (0 = ID, 1 = timestamp)
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  read data qualifier
- busy  out  1  sequence in progress
- done  out  1  sequence finished; level, held until next accepted start
- id_ok  out  1  captured ID == EXPECTED_ID
- ts_ok  out  1  captured timestamp == EXPECTED_TIMESTAMP
- pass  out  1  id_ok & ts_ok & done & !timeout
- timeout  out  1  a transaction exceeded TIMEOUT_CYCLES
- id_value  out  32  captured ID word
- ts_value  out  32  captured timestamp word

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE; all outputs 0; timeout counter 0.
- States: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, DONE.
- IDLE/DONE + start: clear id_ok, ts_ok, timeout, id_value, ts_value, done. Go to ID_REQ next cycle. busy=1 from that cycle.
- While busy, start is ignored.
- *_REQ: avm_read=1; avm_address=0 in ID_REQ, 1 in TS_REQ. Address and read held stable while avm_waitrequest=1.
  - Command accepted on the cycle read & !waitrequest; the state then leaves REQ.
  - avm_read deasserts the cycle after acceptance. Only one read is outstanding at a time.
- *_WAIT: avm_read=0. Capture avm_readdata on the first avm_readdatavalid.
- Zero-latency slaves: readdatavalid in the same cycle as acceptance is captured directly from REQ, skipping WAIT.
- After the ID capture: id_ok updates from the registered compare, then go to TS_REQ.
- After the TS capture: ts_ok updates, then go to DONE. done=1 and busy=0 in the cycle after capture.
- Timeout counter:
  - Cleared on entry to each REQ; increments every cycle in REQ/WAIT.
  - Reaching TIMEOUT_CYCLES-1 without capture sets timeout=1 and goes to DONE. avm_read drops immediately. Remaining checks are left 0.
- readdatavalid arriving in IDLE/DONE (a late response after timeout) is ignored. Captured values are unchanged.
- Simultaneous capture and timeout expiry on the same cycle: capture wins, timeout stays 0.
- Reset mid-sequence: immediate return to IDLE with outputs cleared; any in-flight response afterwards is ignored.
- Compare width: full 32-bit equality; no masking.
- Latency with zero-wait, latency-1 slave: start at cycle 0 -> done=1 at cycle 5.

Decomposition:
- Shared package holds:
  - state enum (sysid_chk_state_t)
  - SYSID_ADDR_ID=1'b0, SYSID_ADDR_TS=1'b1
  - default EXPECTED_* constants, shared with the HPS header generator
- One natural sub-module: avm_single_read, a generic single-outstanding read engine with timeout, instantiated once and sequenced twice by the top-level FSM.

Test Plan:
- Slave returns 0 / 1463101460, no waitrequest, latency 1; start pulse at cycle 0 -> reads at addr 0 then addr 1; done=1 at cycle 5; id_ok=ts_ok=pass=1; timeout=0.
- Slave returns timestamp 32'h12345678 -> id_ok=1, ts_ok=0, pass=0, ts_value=32'h12345678.
- waitrequest held 3 cycles on each read -> avm_address/avm_read stable during the stall; exactly one accept per word; done at cycle 11; pass=1.
- TIMEOUT_CYCLES=8, slave never asserts readdatavalid for addr 0 -> timeout=1 eight cycles after ID_REQ entry; done=1; addr 1 never read. A late readdatavalid with 0 leaves id_ok=0.
- start pulsed again mid-sequence -> ignored, single sequence completes. Then start in DONE -> flags cleared and a full re-check runs.
- reset_n low during TS_WAIT -> all outputs 0 asynchronously; a subsequent readdatavalid is ignored; a following start yields a normal pass.
